// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
//
// Streams a program image into instruction memory while the CPU fetch unit is
// held. The source stream carries a two-word header (base address, length in
// words), then the payload words. Each accepted payload word is written one
// cycle later to base + k. Once the last write strobe has gone out, a single
// FINISH cycle redirects fetch to the base address and reports completion.
// A length above MAX_WORDS aborts the session with a sticky error flag.
//
// Parameters
//   MAX_WORDS    largest accepted program length in words
//   ADDR_W       width of write_addr (must be at least 16)
//
// Ports
//   clk          single clock, all state changes on its rising edge
//   rst          asynchronous, active-low reset
//   start        one-cycle session request, sampled only while idle
//   in_valid     source presents a word on in_data
//   in_data      16-bit stream word (header or payload)
//   in_ready     loader accepts in_data this cycle
//   write_enable instruction-memory write strobe, one cycle per payload word
//   write_addr   instruction-memory word address
//   write_data   instruction-memory write data
//   cpu_hold     fetch PC frozen while a session is in progress
//   jump_signal  one-cycle fetch redirect to the loaded program
//   jump_to      redirect target, valid while jump_signal is high
//   load_done    one-cycle pulse on successful completion
//   load_err     sticky length error, cleared by the next accepted start
// -----------------------------------------------------------------------------
module program_loader #(
  parameter int MAX_WORDS = 1024,
  parameter int ADDR_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  input  logic [15:0]       in_data,
  output logic              in_ready,
  output logic              write_enable,
  output logic [ADDR_W-1:0] write_addr,
  output logic [15:0]       write_data,
  output logic              cpu_hold,
  output logic              jump_signal,
  output logic [15:0]       jump_to,
  output logic              load_done,
  output logic              load_err
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_HDR_ADDR = 3'd1,
    ST_HDR_LEN  = 3'd2,
    ST_LOAD     = 3'd3,
    ST_FINISH   = 3'd4
  } state_t;

  localparam logic [31:0] MAX_LEN = 32'(MAX_WORDS);

  state_t            state_r;
  logic [ADDR_W-1:0] base_r;
  logic [15:0]       len_r;
  logic [15:0]       count_r;
  logic              in_ready_r;
  logic              write_enable_r;
  logic [ADDR_W-1:0] write_addr_r;
  logic [15:0]       write_data_r;
  logic              cpu_hold_r;
  logic              jump_signal_r;
  logic [15:0]       jump_to_r;
  logic              load_done_r;
  logic              load_err_r;

  logic accept_s;
  logic last_word_s;
  logic too_long_s;

  assign accept_s    = in_valid && in_ready_r;
  // count_r holds the number of payload words already accepted
  assign last_word_s = ((count_r + 16'd1) == len_r);
  assign too_long_s  = ({16'd0, in_data} > MAX_LEN);

  assign in_ready     = in_ready_r;
  assign write_enable = write_enable_r;
  assign write_addr   = write_addr_r;
  assign write_data   = write_data_r;
  assign cpu_hold     = cpu_hold_r;
  assign jump_signal  = jump_signal_r;
  assign jump_to      = jump_to_r;
  assign load_done    = load_done_r;
  assign load_err     = load_err_r;

  // Session FSM with all outputs registered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r        <= ST_IDLE;
      base_r         <= '0;
      len_r          <= 16'd0;
      count_r        <= 16'd0;
      in_ready_r     <= 1'b0;
      write_enable_r <= 1'b0;
      write_addr_r   <= '0;
      write_data_r   <= 16'd0;
      cpu_hold_r     <= 1'b0;
      jump_signal_r  <= 1'b0;
      jump_to_r      <= 16'd0;
      load_done_r    <= 1'b0;
      load_err_r     <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below
      write_enable_r <= 1'b0;
      jump_signal_r  <= 1'b0;
      load_done_r    <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (start) begin
            state_r    <= ST_HDR_ADDR;
            cpu_hold_r <= 1'b1;
            load_err_r <= 1'b0;
            in_ready_r <= 1'b1;
          end else begin
            state_r    <= ST_IDLE;
          end
        end

        ST_HDR_ADDR: begin
          if (accept_s) begin
            base_r  <= ADDR_W'(in_data);
            state_r <= ST_HDR_LEN;
          end else begin
            state_r <= ST_HDR_ADDR;
          end
        end

        ST_HDR_LEN: begin
          if (accept_s) begin
            len_r   <= in_data;
            count_r <= 16'd0;
            if (in_data == 16'd0) begin
              // Empty program: redirect straight away, nothing to write
              state_r       <= ST_FINISH;
              in_ready_r    <= 1'b0;
              jump_signal_r <= 1'b1;
              load_done_r   <= 1'b1;
              jump_to_r     <= base_r[15:0];
            end else if (too_long_s) begin
              state_r    <= ST_IDLE;
              in_ready_r <= 1'b0;
              cpu_hold_r <= 1'b0;
              load_err_r <= 1'b1;
            end else begin
              state_r    <= ST_LOAD;
            end
          end else begin
            state_r <= ST_HDR_LEN;
          end
        end

        ST_LOAD: begin
          if (accept_s) begin
            write_enable_r <= 1'b1;
            write_data_r   <= in_data;
            write_addr_r   <= base_r + ADDR_W'(count_r);
            count_r        <= count_r + 16'd1;
            if (last_word_s) begin
              in_ready_r <= 1'b0;
            end else begin
              in_ready_r <= 1'b1;
            end
          end else if (!in_ready_r) begin
            // Last word was taken on the previous edge and its strobe is
            // now completing, so FINISH starts after it.
            state_r       <= ST_FINISH;
            jump_signal_r <= 1'b1;
            load_done_r   <= 1'b1;
            jump_to_r     <= base_r[15:0];
          end else begin
            state_r <= ST_LOAD;
          end
        end

        ST_FINISH: begin
          state_r    <= ST_IDLE;
          cpu_hold_r <= 1'b0;
          in_ready_r <= 1'b0;
        end

        default: begin
          state_r    <= ST_IDLE;
          in_ready_r <= 1'b0;
          cpu_hold_r <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
//
// Self-checking bench for program_loader. A table of sessions (header, payload
// pattern, source gaps and expected outcome) is applied in a loop, followed by
// randomized sessions and a mid-session reset sequence. A negedge monitor logs
// every write strobe and redirect; expected writes come from the rule
// "word k of an accepted program lands at base + k".
// -----------------------------------------------------------------------------
module tb_program_loader;

  localparam int MAXW = 8;
  localparam int AW   = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          in_valid = 1'b0;
  logic [15:0]   in_data = 16'd0;
  logic          in_ready;
  logic          write_enable;
  logic [AW-1:0] write_addr;
  logic [15:0]   write_data;
  logic          cpu_hold;
  logic          jump_signal;
  logic [15:0]   jump_to;
  logic          load_done;
  logic          load_err;

  always #5 clk = ~clk;

  program_loader #(.MAX_WORDS(MAXW), .ADDR_W(AW)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .write_enable (write_enable),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .cpu_hold     (cpu_hold),
    .jump_signal  (jump_signal),
    .jump_to      (jump_to),
    .load_done    (load_done),
    .load_err     (load_err)
  );

  typedef struct packed {
    logic [31:0] addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    logic [15:0] base;
    logic [15:0] len;
    logic [15:0] pay0;
    logic [15:0] step;
    int          gap;
    int          exp_wr;
    bit          exp_jump;
    bit          exp_err;
    logic [31:0] exp_last;
  } vec_t;

  int          n_checks = 0;
  int          n_fail   = 0;
  wr_t         wr_log[$];
  logic [15:0] pay_q[$];
  int          jump_cnt = 0;
  int          done_cnt = 0;
  int          cyc = 0;
  int          last_wr_cyc = 0;
  int          jump_cyc = 0;
  logic [15:0] jump_last = 16'd0;
  bit          mon_en = 1'b0;
  bit          drv_payload = 1'b0;
  logic        acc_prev = 1'b0;
  logic        jump_prev = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  // Log strobes and check that each write follows a payload acceptance
  always @(negedge clk) begin
    cyc++;
    if (mon_en) begin
      check("we_timing", 64'(write_enable), 64'(acc_prev));
      if (write_enable === 1'b1) begin
        wr_log.push_back('{addr: write_addr, data: write_data});
        last_wr_cyc = cyc;
      end
      if (jump_signal === 1'b1) begin
        jump_cnt++;
        jump_cyc  = cyc;
        jump_last = jump_to;
        check("jump_with_done", 64'(load_done), 64'(1));
        check("jump_hold", 64'(cpu_hold), 64'(1));
        check("jump_no_write", 64'(write_enable), 64'(0));
      end
      if (load_done === 1'b1) done_cnt++;
      if (jump_prev === 1'b1) begin
        check("hold_release", 64'(cpu_hold), 64'(0));
        check("jump_one_cycle", 64'(jump_signal), 64'(0));
      end
      jump_prev = jump_signal;
      acc_prev  = in_valid && in_ready && drv_payload;
    end else begin
      acc_prev  = 1'b0;
      jump_prev = 1'b0;
    end
  end

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"},     64'(in_ready),     64'(0));
    check({tag, ".write_enable"}, 64'(write_enable), 64'(0));
    check({tag, ".write_addr"},   64'(write_addr),   64'(0));
    check({tag, ".write_data"},   64'(write_data),   64'(0));
    check({tag, ".cpu_hold"},     64'(cpu_hold),     64'(0));
    check({tag, ".jump_signal"},  64'(jump_signal),  64'(0));
    check({tag, ".jump_to"},      64'(jump_to),      64'(0));
    check({tag, ".load_done"},    64'(load_done),    64'(0));
    check({tag, ".load_err"},     64'(load_err),     64'(0));
  endtask

  // Present one word after `gap` idle cycles and hold it until accepted
  task automatic push_word(input logic [15:0] w, input bit payload, input int gap);
    int t;
    in_valid = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    in_valid    = 1'b1;
    in_data     = w;
    drv_payload = payload;
    t = 0;
    while (in_ready !== 1'b1 && t < 40) begin
      @(posedge clk); #1;
      t++;
    end
    check("ready_wait", 64'(in_ready), 64'(1));
    if (in_ready === 1'b1) begin
      @(posedge clk); #1;
    end
  endtask

  // One full session; payload comes from pay_q, gap<0 means random gaps
  task automatic run_session(input string tag, input logic [15:0] base,
                             input logic [15:0] len, input int gap);
    int n_exp;
    bit err_exp;
    int t;
    err_exp = (32'(len) > 32'(MAXW));
    n_exp   = err_exp ? 0 : int'(len);
    wr_log.delete();
    jump_cnt    = 0;
    done_cnt    = 0;
    last_wr_cyc = 0;
    jump_cyc    = 0;
    jump_last   = 16'd0;
    mon_en      = 1'b1;

    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ".hold_on_start"},  64'(cpu_hold), 64'(1));
    check({tag, ".ready_on_start"}, 64'(in_ready), 64'(1));
    check({tag, ".err_cleared"},    64'(load_err), 64'(0));

    push_word(base, 1'b0, 0);
    push_word(len,  1'b0, 0);
    for (int k = 0; k < n_exp; k++) begin
      push_word(pay_q[k], 1'b1,
                (k == 0) ? 0 : ((gap < 0) ? int'($urandom_range(0, 2)) : gap));
    end
    in_valid    = 1'b0;
    drv_payload = 1'b0;

    t = 0;
    while (cpu_hold === 1'b1 && t < 30) begin
      @(posedge clk); #1;
      t++;
    end
    check({tag, ".hold_dropped"}, 64'(cpu_hold), 64'(0));
    repeat (3) begin
      @(posedge clk); #1;
    end

    check({tag, ".wr_count"}, 64'(wr_log.size()), 64'(n_exp));
    for (int k = 0; k < wr_log.size() && k < n_exp; k++) begin
      check($sformatf("%s.addr[%0d]", tag, k), 64'(wr_log[k].addr), 64'(32'(base) + 32'(k)));
      check($sformatf("%s.data[%0d]", tag, k), 64'(wr_log[k].data), 64'(pay_q[k]));
    end
    check({tag, ".jump_cnt"}, 64'(jump_cnt), 64'(err_exp ? 0 : 1));
    check({tag, ".done_cnt"}, 64'(done_cnt), 64'(err_exp ? 0 : 1));
    if (!err_exp) begin
      check({tag, ".jump_to"}, 64'(jump_last), 64'(base));
    end
    if (n_exp > 0) begin
      check({tag, ".jump_after_writes"}, 64'(jump_cyc > last_wr_cyc), 64'(1));
    end
    check({tag, ".load_err"},  64'(load_err), 64'(err_exp));
    check({tag, ".ready_end"}, 64'(in_ready), 64'(0));
  endtask

  initial begin
    vec_t        vecs[7];
    logic [15:0] rbase;
    logic [15:0] rlen;

    vecs[0] = '{16'h0020, 16'd3, 16'hA001, 16'h0001, 0, 3, 1'b1, 1'b0, 32'h0000_0022};
    vecs[1] = '{16'h0020, 16'd3, 16'hA001, 16'h0001, 2, 3, 1'b1, 1'b0, 32'h0000_0022};
    vecs[2] = '{16'h0040, 16'd0, 16'h0000, 16'h0000, 0, 0, 1'b1, 1'b0, 32'h0000_0000};
    vecs[3] = '{16'h0000, 16'(MAXW + 1), 16'h0000, 16'h0000, 0, 0, 1'b0, 1'b1, 32'h0000_0000};
    vecs[4] = '{16'hFFFF, 16'd2, 16'h1111, 16'h1111, 0, 2, 1'b1, 1'b0, 32'h0001_0000};
    vecs[5] = '{16'h1234, 16'(MAXW), 16'h0101, 16'h0101, 1, MAXW, 1'b1, 1'b0, 32'h0000_123B};
    vecs[6] = '{16'h8000, 16'd1, 16'hBEEF, 16'h0000, 0, 1, 1'b1, 1'b0, 32'h0000_8000};

    // Reset state
    #1 rst = 1'b0;
    #2 check_all_zero("reset");
    #9 rst = 1'b1;

    // Table-driven sessions; the first start lands on the first edge out of reset
    for (int v = 0; v < 7; v++) begin
      pay_q.delete();
      for (int k = 0; k < int'(vecs[v].len) && k <= MAXW; k++) begin
        pay_q.push_back(vecs[v].pay0 + 16'(k) * vecs[v].step);
      end
      run_session($sformatf("vec%0d", v), vecs[v].base, vecs[v].len, vecs[v].gap);
      check($sformatf("vec%0d.tbl_wr", v),   64'(wr_log.size()), 64'(vecs[v].exp_wr));
      check($sformatf("vec%0d.tbl_jump", v), 64'(jump_cnt),      64'(vecs[v].exp_jump));
      check($sformatf("vec%0d.tbl_err", v),  64'(load_err),      64'(vecs[v].exp_err));
      if (vecs[v].exp_wr > 0 && wr_log.size() > 0) begin
        check($sformatf("vec%0d.tbl_last", v), 64'(wr_log[wr_log.size() - 1].addr),
              64'(vecs[v].exp_last));
      end
    end

    // Randomized sessions against the base + k model
    for (int r = 0; r < 12; r++) begin
      rbase = 16'($urandom);
      rlen  = 16'($urandom_range(0, MAXW + 2));
      pay_q.delete();
      for (int k = 0; k <= MAXW; k++) pay_q.push_back(16'($urandom));
      run_session($sformatf("rnd%0d", r), rbase, rlen, -1);
    end

    // Reset after the second of four payload words
    pay_q.delete();
    pay_q.push_back(16'hC001);
    pay_q.push_back(16'hC002);
    wr_log.delete();
    mon_en = 1'b1;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    push_word(16'h0100, 1'b0, 0);
    push_word(16'd4,    1'b0, 0);
    push_word(pay_q[0], 1'b1, 0);
    push_word(pay_q[1], 1'b1, 0);
    in_valid = 1'b1;
    in_data  = 16'hC003;
    mon_en   = 1'b0;
    #1 rst = 1'b0;
    #1 check_all_zero("midrst");
    #4 rst = 1'b1;
    @(posedge clk); #1;
    wr_log.delete();
    jump_cnt = 0;
    done_cnt = 0;
    mon_en   = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
    end
    in_valid    = 1'b0;
    drv_payload = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("midrst.no_write", 64'(wr_log.size()), 64'(0));
    check("midrst.no_jump",  64'(jump_cnt),      64'(0));
    check("midrst.no_done",  64'(done_cnt),      64'(0));
    check("midrst.hold",     64'(cpu_hold),      64'(0));
    check("midrst.ready",    64'(in_ready),      64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
